// File: rtl/eth_mac_stats_pkg.sv
// Shared definitions for the Ethernet MAC statistics block: counter map,
// saturating arithmetic and tkeep popcount.
package eth_mac_stats_pkg;

  localparam int IDX_TX_FRAMES          = 0;
  localparam int IDX_TX_BYTES           = 1;
  localparam int IDX_RX_GOOD_FRAMES     = 2;
  localparam int IDX_RX_BAD_FRAMES_USER = 3;
  localparam int IDX_RX_BYTES           = 4;
  localparam int IDX_RX_ERROR_BAD_FRAME = 5;
  localparam int IDX_RX_ERROR_BAD_FCS   = 6;
  localparam int IDX_RX_FIFO_OVERFLOW   = 7;
  localparam int IDX_RX_FIFO_BAD_FRAME  = 8;
  localparam int IDX_TX_ERROR_UNDERFLOW = 9;
  localparam int IDX_TX_FIFO_OVERFLOW   = 10;
  localparam int IDX_TX_FIFO_BAD_FRAME  = 11;
  localparam int NUM_COUNTERS           = 12;
  localparam int NUM_ADDRESSES          = 16;

  // Sum is formed one bit wider than any legal counter so overflow is visible before clamping.
  function automatic logic [63:0] sat_add(input logic [63:0] value, input logic [63:0] amount,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] max;
    max = (65'd1 << width) - 65'd1;
    sum = {1'b0, value} + {1'b0, amount};
    return (sum > max) ? max[63:0] : sum[63:0];
  endfunction

  function automatic logic [7:0] keep_popcount(input logic [127:0] keep);
    logic [7:0] total;
    total = '0;
    for (int i = 0; i < 128; i++) total = total + 8'(keep[i]);
    return total;
  endfunction

endpackage

// File: rtl/eth_mac_stats_if.sv
// Snooped TX/RX streams, MAC status pulses and the counter read port.
interface eth_mac_stats_if #(
  parameter int KEEP_WIDTH  = 1,
  parameter int COUNT_WIDTH = 32
);
  logic [KEEP_WIDTH-1:0]  tx_axis_tkeep;
  logic                   tx_axis_tvalid;
  logic                   tx_axis_tready;
  logic                   tx_axis_tlast;
  logic [KEEP_WIDTH-1:0]  rx_axis_tkeep;
  logic                   rx_axis_tvalid;
  logic                   rx_axis_tready;
  logic                   rx_axis_tlast;
  logic                   rx_axis_tuser;
  logic                   tx_error_underflow;
  logic                   tx_fifo_overflow;
  logic                   tx_fifo_bad_frame;
  logic                   rx_error_bad_frame;
  logic                   rx_error_bad_fcs;
  logic                   rx_fifo_overflow;
  logic                   rx_fifo_bad_frame;
  logic                   stat_clear;
  logic                   stat_snapshot;
  logic                   stat_rd_req;
  logic [3:0]             stat_rd_addr;
  logic                   stat_rd_ack;
  logic [COUNT_WIDTH-1:0] stat_rd_data;

  modport master (
    output tx_axis_tkeep, tx_axis_tvalid, tx_axis_tready, tx_axis_tlast,
    output rx_axis_tkeep, rx_axis_tvalid, rx_axis_tready, rx_axis_tlast, rx_axis_tuser,
    output tx_error_underflow, tx_fifo_overflow, tx_fifo_bad_frame,
    output rx_error_bad_frame, rx_error_bad_fcs, rx_fifo_overflow, rx_fifo_bad_frame,
    output stat_clear, stat_snapshot, stat_rd_req, stat_rd_addr,
    input  stat_rd_ack, stat_rd_data
  );

  modport slave (
    input  tx_axis_tkeep, tx_axis_tvalid, tx_axis_tready, tx_axis_tlast,
    input  rx_axis_tkeep, rx_axis_tvalid, rx_axis_tready, rx_axis_tlast, rx_axis_tuser,
    input  tx_error_underflow, tx_fifo_overflow, tx_fifo_bad_frame,
    input  rx_error_bad_frame, rx_error_bad_fcs, rx_fifo_overflow, rx_fifo_bad_frame,
    input  stat_clear, stat_snapshot, stat_rd_req, stat_rd_addr,
    output stat_rd_ack, stat_rd_data
  );
endinterface

// File: rtl/eth_mac_stats_counter.sv
// One saturating statistics counter; clear takes priority over the increment.
module eth_mac_stats_counter
  import eth_mac_stats_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter int INC_WIDTH   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [INC_WIDTH-1:0]   inc,
  output logic [COUNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= COUNT_WIDTH'(sat_add(64'(count), 64'(inc), COUNT_WIDTH));
    end
  end

endmodule

// File: rtl/eth_mac_stats.sv
// Passive MAC statistics: snoops user-side AXI streams and status pulses into saturating counters.
// Optional shadow bank for coherent reads is enabled with `define ETH_MAC_STATS_SNAPSHOT_EN.
module eth_mac_stats
  import eth_mac_stats_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 8,
  parameter int AXIS_KEEP_ENABLE = (AXIS_DATA_WIDTH > 8),
  parameter int AXIS_KEEP_WIDTH  = (AXIS_DATA_WIDTH / 8),
  parameter int COUNT_WIDTH      = 32
) (
  input logic            clk,
  input logic            rst,
  eth_mac_stats_if.slave bus
);

  localparam int INC_WIDTH = $clog2(AXIS_KEEP_WIDTH + 1);

  logic                   tx_beat;
  logic                   rx_beat;
  logic [INC_WIDTH-1:0]   inc        [NUM_COUNTERS];
  logic [COUNT_WIDTH-1:0] live       [NUM_COUNTERS];
  logic [COUNT_WIDTH-1:0] bank       [NUM_COUNTERS];
  logic [COUNT_WIDTH-1:0] read_table [NUM_ADDRESSES];
  logic                   rd_ack;
  logic [COUNT_WIDTH-1:0] rd_data;

  function automatic logic [INC_WIDTH-1:0] beat_bytes(input logic [AXIS_KEEP_WIDTH-1:0] keep);
    if (AXIS_KEEP_ENABLE != 0) return INC_WIDTH'(keep_popcount(128'(keep)));
    return INC_WIDTH'(AXIS_KEEP_WIDTH);
  endfunction

  assign tx_beat = bus.tx_axis_tvalid & bus.tx_axis_tready;
  assign rx_beat = bus.rx_axis_tvalid & bus.rx_axis_tready;

  always_comb begin
    inc[IDX_TX_FRAMES]          = INC_WIDTH'(tx_beat & bus.tx_axis_tlast);
    inc[IDX_TX_BYTES]           = tx_beat ? beat_bytes(bus.tx_axis_tkeep) : '0;
    inc[IDX_RX_GOOD_FRAMES]     = INC_WIDTH'(rx_beat & bus.rx_axis_tlast & ~bus.rx_axis_tuser);
    inc[IDX_RX_BAD_FRAMES_USER] = INC_WIDTH'(rx_beat & bus.rx_axis_tlast & bus.rx_axis_tuser);
    inc[IDX_RX_BYTES]           = rx_beat ? beat_bytes(bus.rx_axis_tkeep) : '0;
    inc[IDX_RX_ERROR_BAD_FRAME] = INC_WIDTH'(bus.rx_error_bad_frame);
    inc[IDX_RX_ERROR_BAD_FCS]   = INC_WIDTH'(bus.rx_error_bad_fcs);
    inc[IDX_RX_FIFO_OVERFLOW]   = INC_WIDTH'(bus.rx_fifo_overflow);
    inc[IDX_RX_FIFO_BAD_FRAME]  = INC_WIDTH'(bus.rx_fifo_bad_frame);
    inc[IDX_TX_ERROR_UNDERFLOW] = INC_WIDTH'(bus.tx_error_underflow);
    inc[IDX_TX_FIFO_OVERFLOW]   = INC_WIDTH'(bus.tx_fifo_overflow);
    inc[IDX_TX_FIFO_BAD_FRAME]  = INC_WIDTH'(bus.tx_fifo_bad_frame);
  end

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_counter
    eth_mac_stats_counter #(
      .COUNT_WIDTH(COUNT_WIDTH),
      .INC_WIDTH  (INC_WIDTH)
    ) u_counter (
      .clk  (clk),
      .rst  (rst),
      .clear(bus.stat_clear),
      .inc  (inc[g]),
      .count(live[g])
    );
  end

`ifdef ETH_MAC_STATS_SNAPSHOT_EN
  // Shadow copies the registered live values, so a same-cycle clear or increment is not captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COUNTERS; i++) bank[i] <= '0;
    end else if (bus.stat_snapshot) begin
      for (int i = 0; i < NUM_COUNTERS; i++) bank[i] <= live[i];
    end
  end
`else
  logic unused_snapshot;
  assign unused_snapshot = bus.stat_snapshot;

  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) bank[i] = live[i];
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_ADDRESSES; i++) read_table[i] = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) read_table[i] = bank[i];
  end

  // Read data is sampled from the registers before this edge's update, and held between acks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= bus.stat_rd_req;
      if (bus.stat_rd_req) rd_data <= read_table[bus.stat_rd_addr];
    end
  end

  assign bus.stat_rd_ack  = rd_ack;
  assign bus.stat_rd_data = rd_data;

endmodule
